ysyx_25020047_wbu_pipe: RTL
===========================

// Module: ysyx_25020047_wbu_pipe
// PURPOSE
//  Parametrised, handshaked write-back stage between EXU/LSU and the register file / IFU.
//  Accepts one retiring instruction per transfer and waits for load data when needed.
//  Performs load byte/half extraction and extension, writes the GPR, and issues the
//  next PC to the IFU. Keeps a retired-instruction counter.
// PARAMETERS
//  XLEN    32  datapath width; >= 32
//  NR_REG  32  GPR count (16 for RV32E); AW = $clog2(NR_REG)
//  CNT_W   64  retire counter width
// PORTS
//  clk             in   1     clock, all state on posedge
//  rst             in   1     synchronous reset, active-high
//  in_valid        in   1     upstream instruction valid
//  in_ready        out  1     stage can accept this cycle
//  in_wb_sel       in   3     0 NONE, 1 ALU(result), 2 LINK(snpc), 3 LOAD, 4 CSR; 5-7 = NONE
//  in_pc_sel       in   2     0 SEQ(snpc), 1 ALU(result), 2 MTVEC, 3 MEPC
//  in_rd           in   AW    destination register
//  in_result       in   XLEN  ALU/branch-target result
//  in_snpc         in   XLEN  pc+4
//  in_csr_rdata    in   XLEN  old CSR value (csrrw/csrrs)
//  in_mtvec        in   XLEN  trap vector
//  in_mepc         in   XLEN  return PC
//  in_ld_size      in   2     0 byte, 1 half, 2 word, 3 = word
//  in_ld_unsigned  in   1     1 = zero-extend, 0 = sign-extend
//  in_ld_off       in   2     load address[1:0]
//  mem_rvalid      in   1     load data valid
//  mem_rdata       in   32    aligned 32-bit word containing the load
//  mem_rerr        in   1     load bus error, qualified by mem_rvalid
//  rf_wen          out  1     GPR write strobe, single cycle
//  rf_waddr        out  AW    GPR write index
//  rf_wdata        out  XLEN  GPR write data
//  npc_valid       out  1     next PC valid to IFU
//  npc_ready       in   1     IFU takes next PC
//  npc             out  XLEN  next PC
//  ld_fault        out  1     one-cycle pulse at commit of a faulted load
//  retire_cnt      out  CNT_W committed instruction count
// BEHAVIOUR
//  - FSM states IDLE, WAIT_MEM, COMMIT. Reset: state IDLE; retire_cnt 0; outputs 0.
//  - in_ready = (IDLE) | (COMMIT & npc_ready). Accept = in_valid & in_ready; capture all in_* fields.
//  - Accept with wb_sel LOAD -> WAIT_MEM; any other accept -> COMMIT.
//  - WAIT_MEM: mem_rvalid ignored outside this state. On mem_rvalid, latch the extended
//    data and rerr, then go to COMMIT.
//  - Load extract: byte = rdata[8*off +: 8]. Half = rdata[16*off[1] +: 16], off[0] ignored.
//    Word = rdata. Sign- or zero-extend to XLEN per in_ld_unsigned.
//  - COMMIT: npc_valid=1, held with stable npc until npc_ready. Commit = npc_valid & npc_ready.
//  - npc by pc_sel: SEQ->snpc, ALU->result, MTVEC->mtvec, MEPC->mepc.
//    Faulted load overrides npc to mtvec.
//  - rf_wen is high only in the commit cycle. It requires wb_sel != NONE, rd != 0, and no load fault.
//    rf_wdata: ALU->result, LINK->snpc, LOAD->extracted data, CSR->csr_rdata.
//  - rf_waddr/rf_wdata are valid whenever rf_wen=1. Otherwise they hold the last value.
//  - Commit: retire_cnt += 1, wrapping mod 2^CNT_W. ld_fault pulses if the load faulted.
//  - Commit plus same-cycle accept: load next in; go to WAIT_MEM/COMMIT per new wb_sel.
//    This gives 1 instr/cycle throughput.
//  - Commit without accept -> IDLE.
//  - Latency: non-load accepted at cycle N commits at cycle N+1 at the earliest.
//    Load commits 1 cycle after mem_rvalid at the earliest.
//  - rst mid-operation (any state): abort and go to IDLE. The in-flight instruction gets no
//    rf_wen, npc_valid, or count. A mem_rvalid arriving later is ignored.
// TESTING
//  - Reset, then addi x5 (wb ALU, result=0x10, snpc=0x80000004, npc_ready=1): accept at N.
//    At N+1: rf_wen, waddr=5, wdata=0x10, npc=0x80000004, retire_cnt=1.
//  - Back-to-back: 4 ALU instrs with in_valid held and npc_ready=1 give 4 commits in 4
//    consecutive cycles; in_ready stays 1.
//  - lb off=3 with rdata=0x80FF1234 -> wdata=0xFFFFFF80. lhu off=2 -> 0x000080FF.
//    lh off=0 -> 0x00001234. mem_rvalid delayed 5 cycles -> npc_valid is 0 until then.
//  - jal rd=0 (LINK, pc_sel ALU, result=0x80000100): no rf_wen; npc=0x80000100.
//    Hold npc_ready=0 for 3 cycles: npc stays stable, in_ready=0, count increments once.
//  - Load with mem_rerr=1, mtvec=0x80000400: no rf_wen, ld_fault pulse, npc=0x80000400.
//    ecall -> npc=mtvec. mret -> npc=mepc. csrrw rd=7 -> wdata=csr_rdata.
//  - rst asserted in WAIT_MEM, then mem_rvalid: no write, no npc_valid, retire_cnt=0, in_ready=1.
//    With CNT_W=4: 16 commits wrap retire_cnt to 0.

Source files
------------

// File: rtl/ysyx_25020047_wbu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_wbu_pipe
// Purpose  : Handshaked write-back stage between EXU/LSU and the register
//            file / IFU. Accepts one retiring instruction per transfer and
//            waits for load data when the instruction is a load. It performs
//            byte/half extraction and extension, writes the GPR, issues the
//            next PC and counts retired instructions.
// Ports    : clk, rst                     clock / synchronous active-high reset
//            in_*_i, in_ready_o           upstream instruction handshake+fields
//            mem_rvalid_i/rdata_i/rerr_i  load data return
//            rf_wen_o/waddr_o/wdata_o     GPR write port (single-cycle strobe)
//            npc_valid_o/ready_i, npc_o   next-PC handshake to the IFU
//            ld_fault_o                   pulse at commit of a faulted load
//            retire_cnt_o                 committed instruction count
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_wbu_pipe #(
  parameter  int XLEN   = 32,
  parameter  int NR_REG = 32,
  parameter  int CNT_W  = 64,
  localparam int AW     = $clog2(NR_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_wb_sel_i,
  input  logic [1:0]       in_pc_sel_i,
  input  logic [AW-1:0]    in_rd_i,
  input  logic [XLEN-1:0]  in_result_i,
  input  logic [XLEN-1:0]  in_snpc_i,
  input  logic [XLEN-1:0]  in_csr_rdata_i,
  input  logic [XLEN-1:0]  in_mtvec_i,
  input  logic [XLEN-1:0]  in_mepc_i,
  input  logic [1:0]       in_ld_size_i,
  input  logic             in_ld_unsigned_i,
  input  logic [1:0]       in_ld_off_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_rerr_i,
  output logic             rf_wen_o,
  output logic [AW-1:0]    rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             npc_valid_o,
  input  logic             npc_ready_i,
  output logic [XLEN-1:0]  npc_o,
  output logic             ld_fault_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_LINK = 3'd2;
  localparam logic [2:0] WB_LOAD = 3'd3;
  localparam logic [2:0] WB_CSR  = 3'd4;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_MTVEC = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;

  // Captured instruction fields
  logic [2:0]        wb_sel_q;
  logic [1:0]        pc_sel_q;
  logic [AW-1:0]     rd_q;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   snpc_q;
  logic [XLEN-1:0]   csr_rdata_q;
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mepc_q;
  logic [1:0]        ld_size_q;
  logic              ld_uns_q;
  logic [1:0]        ld_off_q;

  // Load return, already extended
  logic [XLEN-1:0]   ld_data_q;
  logic              ld_err_q;

  // Last GPR write, held on the write port between strobes
  logic [AW-1:0]     waddr_q;
  logic [XLEN-1:0]   wdata_q;

  logic [CNT_W-1:0]  retire_cnt_q;

  logic              w_accept;
  logic              w_commit;
  logic              w_fault;
  logic              w_wb_en;
  logic              w_rf_wen;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_npc;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_ld_ext;

  assign in_ready_o = (state_q == IDLE) || ((state_q == COMMIT) && npc_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_commit   = (state_q == COMMIT) && npc_ready_i;
  assign w_fault    = (wb_sel_q == WB_LOAD) && ld_err_q;
  // Encodings 5-7 behave as NONE
  assign w_wb_en    = (wb_sel_q != 3'd0) && (wb_sel_q <= WB_CSR);
  assign w_rf_wen   = w_commit && w_wb_en && (rd_q != '0) && !w_fault;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = (in_wb_sel_i == WB_LOAD) ? WAIT_MEM : COMMIT;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (npc_ready_i) begin
          if (w_accept) begin
            state_d = (in_wb_sel_i == WB_LOAD) ? WAIT_MEM : COMMIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load extraction: the half select uses only off[1]
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (ld_off_q)
      2'd0:    w_byte = mem_rdata_i[7:0];
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      default: w_byte = mem_rdata_i[31:24];
    endcase
    w_half = ld_off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    w_ld_ext = '0;
    case (ld_size_q)
      2'd0:    w_ld_ext = ld_uns_q ? XLEN'(w_byte) : XLEN'($signed(w_byte));
      2'd1:    w_ld_ext = ld_uns_q ? XLEN'(w_half) : XLEN'($signed(w_half));
      default: w_ld_ext = ld_uns_q ? XLEN'(mem_rdata_i) : XLEN'($signed(mem_rdata_i));
    endcase
  end

  // Write-back data and next-PC selection
  always_comb begin
    w_wdata = result_q;
    case (wb_sel_q)
      WB_ALU:  w_wdata = result_q;
      WB_LINK: w_wdata = snpc_q;
      WB_LOAD: w_wdata = ld_data_q;
      WB_CSR:  w_wdata = csr_rdata_q;
      default: w_wdata = result_q;
    endcase

    w_npc = snpc_q;
    if (w_fault) begin
      w_npc = mtvec_q;
    end else begin
      case (pc_sel_q)
        PC_SEQ:   w_npc = snpc_q;
        PC_ALU:   w_npc = result_q;
        PC_MTVEC: w_npc = mtvec_q;
        default:  w_npc = mepc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wb_sel_q     <= '0;
      pc_sel_q     <= '0;
      rd_q         <= '0;
      result_q     <= '0;
      snpc_q       <= '0;
      csr_rdata_q  <= '0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      ld_size_q    <= '0;
      ld_uns_q     <= 1'b0;
      ld_off_q     <= '0;
      ld_data_q    <= '0;
      ld_err_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (w_accept) begin
        wb_sel_q    <= in_wb_sel_i;
        pc_sel_q    <= in_pc_sel_i;
        rd_q        <= in_rd_i;
        result_q    <= in_result_i;
        snpc_q      <= in_snpc_i;
        csr_rdata_q <= in_csr_rdata_i;
        mtvec_q     <= in_mtvec_i;
        mepc_q      <= in_mepc_i;
        ld_size_q   <= in_ld_size_i;
        ld_uns_q    <= in_ld_unsigned_i;
        ld_off_q    <= in_ld_off_i;
        // A stale error from a previous load must not fault this one
        ld_err_q    <= 1'b0;
      end

      // Accept can never coincide with WAIT_MEM, so no priority conflict here
      if ((state_q == WAIT_MEM) && mem_rvalid_i) begin
        ld_data_q <= w_ld_ext;
        ld_err_q  <= mem_rerr_i;
      end

      if (w_rf_wen) begin
        waddr_q <= rd_q;
        wdata_q <= w_wdata;
      end

      if (w_commit) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign npc_valid_o  = (state_q == COMMIT);
  assign npc_o        = w_npc;
  assign rf_wen_o     = w_rf_wen;
  // Write port shows the live value in the commit cycle, otherwise the last write
  assign rf_waddr_o   = w_rf_wen ? rd_q : waddr_q;
  assign rf_wdata_o   = w_rf_wen ? w_wdata : wdata_q;
  assign ld_fault_o   = w_commit && w_fault;
  assign retire_cnt_o = retire_cnt_q;

endmodule
`default_nettype wire
